local_network_interface: RTL
============================

# local_network_interface

Endpoint network interface for the LOCAL port of a mesh router. It packs core-side transmit requests into 32-bit flits and injects them into the router's local input FIFO, obeying the router's full backpressure. It also captures flits ejected on the router's local output, which has no backpressure, into a receive queue for the core. It sits between a processing element and its router, one instance per mesh node.

## Interface
Flit format, both directions: [31:6] payload (26 b), [5:3] source address, [2:0] destination address.

Parameters:
- NODE_ADDRESS, 3'b0, this node's mesh address; inserted as the source field on TX and checked against the destination field on RX
- TX_DEPTH, 4, transmit queue entries (power of two, ≥2)
- RX_DEPTH, 4, receive queue entries (power of two, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- tx_dst  in  3  destination address of the core request
- tx_payload  in  26  core request payload
- tx_valid  in  1  core request valid
- tx_ready  out  1  transmit queue can accept a request
- NET_DATA_OUT  out  32  flit to router LOCAL_DATA_IN
- NET_VALID_OUT  out  1  flit valid to router LOCAL_DATA_VALID_IN
- NET_FULL_IN  in  1  router LOCAL_FULL_OUT
- NET_DATA_IN  in  32  flit from router LOCAL_DATA_OUT
- NET_VALID_IN  in  1  router LOCAL_DATA_VALID_OUT
- rx_payload  out  26  head-of-queue payload
- rx_src  out  3  head-of-queue source address
- rx_valid  out  1  receive queue not empty
- rx_ready  in  1  core pops the head entry
- rx_overflow  out  1  sticky: an ejected flit was dropped
- rx_misroute  out  1  sticky: a flit was received with dst ≠ NODE_ADDRESS
- tx_flit_cnt  out  16  count of injected flits
- rx_flit_cnt  out  16  count of accepted flits

## Operation
- TX queue, circular buffer of TX_DEPTH entries:
  - tx_ready = !tx_full. The core cannot see a same-cycle pop.
  - Push occurs on tx_valid && tx_ready. Stored flit = {tx_payload, NODE_ADDRESS, tx_dst}.
- Injection:
  - NET_VALID_OUT = !tx_empty && !NET_FULL_IN. This is the only combinational input-to-output path.
  - NET_DATA_OUT = head entry when NET_VALID_OUT is high, else 0.
  - Pop occurs when NET_VALID_OUT is high; tx_flit_cnt increments on each pop.
- Flits are never reordered.
- A destination equal to NODE_ADDRESS is legal; the router loops it back.
- RX path:
  - Every cycle with NET_VALID_IN high is an ejected flit. It is accepted if !rx_full, or if rx_full && rx_ready in the same cycle.
  - Otherwise the flit is dropped, rx_overflow sets, and rx_flit_cnt does not increment.
- An accepted flit with NET_DATA_IN[2:0] ≠ NODE_ADDRESS is still queued, and rx_misroute sets.
- rx_valid = !rx_empty. rx_payload and rx_src show the head entry, or 0 when empty. The head is popped on rx_valid && rx_ready.
- Occupancy counts are log2(DEPTH)+1 bits wide. Pointers wrap modulo DEPTH.
- Counters are 16-bit, wrap 0xFFFF→0x0000, and have no saturation.
- Sticky flags clear only on rst.

## Timing
- Reset (async assert, sync deassert assumed upstream):
  - Both queues empty, tx_ready=1, NET_VALID_OUT=0, NET_DATA_OUT=0.
  - rx_valid=0, rx_payload=0, rx_src=0, rx_overflow=0, rx_misroute=0, both counters=0.
  - Reset mid-transfer discards all queued flits with no partial output.
- TX latency:
  - A request accepted in cycle N can drive NET_VALID_OUT in cycle N+1 at the earliest.
  - Throughput is one flit per cycle while NET_FULL_IN=0.
- While NET_FULL_IN=1: NET_VALID_OUT=0, the head is held, and the TX queue keeps filling. tx_ready drops the cycle after the TX_DEPTH-th push.
- RX latency: a flit accepted in cycle N appears on rx_valid/rx_payload in cycle N+1.
- Simultaneous push and pop on either queue keeps occupancy unchanged; this is legal on an empty TX queue only after its first entry lands.
- Receiving is independent of transmitting; both may be active in the same cycle.

## Test plan
- Reset, then tx_dst=3'd5, tx_payload=26'h1 with NODE_ADDRESS=3'd2 → next cycle NET_VALID_OUT=1, NET_DATA_OUT=32'h00000055; tx_flit_cnt=1.
- Hold NET_FULL_IN=1 and push 5 requests with TX_DEPTH=4 → NET_VALID_OUT stays 0, tx_ready=0 after the 4th push. Release full → 4 flits drain on consecutive cycles, in order.
- NET_VALID_IN=1 with NET_DATA_IN=32'h00000FD2 and rx_ready=0 → rx_valid=1, rx_src=3'd2, rx_payload=26'h3F, rx_flit_cnt=1, rx_misroute=0.
- Send 5 ejected flits back-to-back with rx_ready=0 and RX_DEPTH=4 → 5th dropped, rx_overflow=1, rx_flit_cnt=4. Repeat with rx_ready=1 in the 5th cycle → accepted, no overflow.
- Ejected flit with dst=3'd7 at NODE_ADDRESS=3'd2 → queued, rx_misroute=1 sticky until rst.
- Assert rst while both queues are half full → all outputs return to reset values immediately; no stale flit appears after deassert.

Source files
------------

// File: rtl/local_network_interface.sv
// local_network_interface
//
// Endpoint network interface for the LOCAL port of a mesh router. Core-side
// transmit requests are packed into 32-bit flits and injected into the
// router's local input FIFO. Injection stalls while the router reports full.
// Flits ejected by the router have no backpressure. They are captured into a
// receive queue that the core drains.
//
// Flit format (both directions): [31:6] payload, [5:3] source, [2:0] destination.
//
// Ports:
//   clk, rst        single rising-edge clock, asynchronous active-high reset
//   tx_dst          destination address of the core request
//   tx_payload      core request payload
//   tx_valid        core request valid
//   tx_ready        transmit queue can accept a request
//   NET_DATA_OUT    flit to router LOCAL_DATA_IN (0 when not valid)
//   NET_VALID_OUT   flit valid to router LOCAL_DATA_VALID_IN
//   NET_FULL_IN     router LOCAL_FULL_OUT
//   NET_DATA_IN     flit from router LOCAL_DATA_OUT
//   NET_VALID_IN    router LOCAL_DATA_VALID_OUT
//   rx_payload      head-of-queue payload (0 when empty)
//   rx_src          head-of-queue source address (0 when empty)
//   rx_valid        receive queue not empty
//   rx_ready        core pops the head entry
//   rx_overflow     sticky: an ejected flit was dropped
//   rx_misroute     sticky: an accepted flit was addressed to another node
//   tx_flit_cnt     wrapping count of injected flits
//   rx_flit_cnt     wrapping count of accepted flits

module local_network_interface #(
  parameter logic [2:0] NODE_ADDRESS = 3'b0,
  parameter int         TX_DEPTH     = 4,
  parameter int         RX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  tx_dst,
  input  logic [25:0] tx_payload,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] NET_DATA_OUT,
  output logic        NET_VALID_OUT,
  input  logic        NET_FULL_IN,
  input  logic [31:0] NET_DATA_IN,
  input  logic        NET_VALID_IN,
  output logic [25:0] rx_payload,
  output logic [2:0]  rx_src,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_overflow,
  output logic        rx_misroute,
  output logic [15:0] tx_flit_cnt,
  output logic [15:0] rx_flit_cnt
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_LEVEL = (TX_AW + 1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_LEVEL = (RX_AW + 1)'(RX_DEPTH);

  // ---------------------------------------------------------------------------
  // Transmit queue
  // ---------------------------------------------------------------------------
  logic [31:0]      tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr;
  logic [TX_AW-1:0] tx_rd_ptr;
  logic [TX_AW:0]   tx_count;
  logic             tx_full;
  logic             tx_empty;
  logic             tx_push;
  logic             tx_pop;

  assign tx_full  = (tx_count == TX_FULL_LEVEL);
  assign tx_empty = (tx_count == '0);
  assign tx_ready = !tx_full;

  // tx_ready only looks at occupancy. A pop in the same cycle does not open
  // a slot for the core until the following cycle.
  assign tx_push = tx_valid && !tx_full;

  // This is the only combinational path from an input to an output.
  // Full backpressure blocks injection in the same cycle.
  assign NET_VALID_OUT = !tx_empty && !NET_FULL_IN;
  assign tx_pop        = NET_VALID_OUT;
  assign NET_DATA_OUT  = NET_VALID_OUT ? tx_mem[tx_rd_ptr] : '0;

  // Queue storage is not reset. The pointers and count define which entries
  // are live, so entries left over from before a reset are never visible.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr] <= {tx_payload, NODE_ADDRESS, tx_dst};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      tx_count    <= '0;
      tx_flit_cnt <= '0;
    end else begin
      if (tx_push) begin
        tx_wr_ptr <= tx_wr_ptr + 1'b1;
      end
      if (tx_pop) begin
        tx_rd_ptr   <= tx_rd_ptr + 1'b1;
        tx_flit_cnt <= tx_flit_cnt + 16'd1;
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive queue
  // ---------------------------------------------------------------------------
  // The destination field is checked on arrival and is not needed later,
  // so each entry holds only {payload, source}.
  logic [28:0]      rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr;
  logic [RX_AW-1:0] rx_rd_ptr;
  logic [RX_AW:0]   rx_count;
  logic             rx_full;
  logic             rx_empty;
  logic             rx_accept;
  logic             rx_drop;
  logic             rx_pop;
  logic [28:0]      rx_head;

  assign rx_full  = (rx_count == RX_FULL_LEVEL);
  assign rx_empty = (rx_count == '0);
  assign rx_valid = !rx_empty;
  assign rx_pop   = !rx_empty && rx_ready;

  // The router cannot be stalled. A flit that arrives while the queue is
  // full is kept only if the core frees the head slot in the same cycle.
  // When that happens, the write slot equals the slot being read, and the
  // head is read combinationally before the write lands.
  assign rx_accept = NET_VALID_IN && (!rx_full || rx_ready);
  assign rx_drop   = NET_VALID_IN && !rx_accept;

  assign rx_head    = rx_empty ? '0 : rx_mem[rx_rd_ptr];
  assign rx_payload = rx_head[28:3];
  assign rx_src     = rx_head[2:0];

  always_ff @(posedge clk) begin
    if (rx_accept) begin
      rx_mem[rx_wr_ptr] <= NET_DATA_IN[31:3];
    end
  end

  // A misrouted flit is still queued so the core can inspect it. Only the
  // sticky flag records the addressing error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      rx_flit_cnt <= '0;
      rx_overflow <= 1'b0;
      rx_misroute <= 1'b0;
    end else begin
      if (rx_accept) begin
        rx_wr_ptr   <= rx_wr_ptr + 1'b1;
        rx_flit_cnt <= rx_flit_cnt + 16'd1;
        if (NET_DATA_IN[2:0] != NODE_ADDRESS) begin
          rx_misroute <= 1'b1;
        end
      end
      if (rx_drop) begin
        rx_overflow <= 1'b1;
      end
      if (rx_pop) begin
        rx_rd_ptr <= rx_rd_ptr + 1'b1;
      end
      case ({rx_accept, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

endmodule
